calc_display_mux: RTL and testbench
===================================

// Module: calc_display_mux
// PURPOSE
// - Multi-digit multiplexed seven-segment driver for the calculator result path.
// - Captures a BCD result and sign, then time-multiplexes one digit per refresh slot onto the shared seg/an pins.
// - Blanks leading zeros and places the minus sign immediately left of the most significant shown digit.
// - Sits between the calculator datapath and the board's common-anode display.
// PARAMETERS
// - NUM_DIGITS   4       digits driven; range 2..8
// - REFRESH_DIV  100000  clk cycles per digit slot; >=2
// - BLINK_DIV    2**25   clk cycles per blink period; even; used only with CALC_DISPLAY_BLINK_EN
// PORTS
// - clk    in   1             system clock; all logic on rising edge
// - rst    in   1             synchronous, active-high reset
// - value  in   4*NUM_DIGITS  BCD result; nibble 0 = units digit
// - neg    in   1             result is negative
// - load   in   1             1-cycle strobe; capture value/neg
// - blink  in   1             flash display (effective only with CALC_DISPLAY_BLINK_EN)
// - seg    out  7             segments {g..a}; active-low; 7'b111_1111 = off
// - an     out  NUM_DIGITS    digit enables; active-low one-hot
// - ovf    out  1             negative result with no free position for the sign
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. Ports are clk and rst.
// - Reset, asserted on any cycle including mid-scan: shadow value = 0, shadow neg = 0, refresh count = 0, scan index = 0.
//   - Outputs while rst is high: seg = 7'h7F, an = all ones, ovf = 0.
//   - First cycle after rst drops: seg = 7'b100_0000 (zero) and an = ~1 (units digit).
// - load: value and neg are registered on the load edge. The new data is used in the decode of the following cycle.
//   - A load in the same cycle as rst is ignored, because rst wins.
// - Refresh counter runs 0..REFRESH_DIV-1.
//   - At terminal count the counter returns to 0 and the scan index advances.
//   - The scan index wraps from NUM_DIGITS-1 to 0.
// - seg and an are registered and follow the scan index with 1 cycle of latency.
//   - an is never all-zero. Exactly one bit is low outside reset.
// - Decode, per nibble:
//   - 0..9 use the standard glyphs: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000.
//   - Nibbles 10..15 decode to off.
// - Leading-zero blanking:
//   - Digit k is blank (off) when nibble k and every higher nibble are 0.
//   - The units digit (k = 0) is never blanked.
// - Sign:
//   - Let m = index of the most significant non-blank digit.
//   - If neg = 1 and m < NUM_DIGITS-1, digit m+1 shows 011_1111 (minus) and ovf = 0.
//   - If neg = 1 and m = NUM_DIGITS-1, no minus is shown and ovf = 1.
//   - Negative zero (value = 0, neg = 1) shows "-0".
// - ovf is registered and updates 1 cycle after the load capture.
// CONFIGURATION
// - CALC_DISPLAY_BLINK_EN defined:
//   - A blink phase counter runs 0..BLINK_DIV-1 and wraps.
//   - While blink = 1 and the phase is in its upper half, seg is forced to 7'h7F. an keeps scanning.
//   - The phase counter resets to 0 on rst and whenever blink = 0.
// - CALC_DISPLAY_BLINK_EN undefined:
//   - The blink port exists but is ignored. There is no phase counter.
// TESTING
// - Sim settings: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16.
// - T1 reset: rst 3 cycles, then release.
//   - Required: seg = 7'h7F and an = 4'hF during reset; next cycle seg = 100_0000 and an = 4'b1110.
// - T2 scan: load value = 16'h1234, neg = 0, run 32 cycles.
//   - Required: an steps 1110 -> 1101 -> 1011 -> 0111 every 4 cycles, then wraps.
//   - Required: seg shows 4, 3, 2, 1 in that order.
// - T3 blanking and sign: load value = 16'h0042, neg = 1.
//   - Required: digit 3 off, digit 2 = 011_1111, digit 1 = 001_1001, digit 0 = 010_0100, ovf = 0.
// - T4 overflow and invalid digit:
//   - Load 16'h9876 with neg = 1. Required: ovf = 1 and no minus glyph on any digit.
//   - Load 16'h00A5. Required: digit 1 = off, digit 0 = 001_0010.
// - T5 reset mid-scan: assert rst while an = 4'b1011.
//   - Required: the next cycle gives an = 4'hF and ovf = 0.
//   - Required: after release the display shows 0 on the units digit.
// - T6 blink (macro defined): blink = 1 for 32 cycles.
//   - Required: seg is forced to 7'h7F in cycles 8..15 and 24..31 of the blink phase. an keeps scanning.
//   - With the macro undefined, seg is unchanged by blink.

Source files
------------

// File: rtl/calc_display_mux.sv
// rtl/calc_display_mux.sv - multiplexed seven-segment driver for the calculator result path
//
// Purpose: captures a BCD result and sign on load, then drives one digit per
// refresh slot onto shared active-low seg/an pins of a common-anode display.
// Leading zeros are blanked and a minus glyph is placed just left of the most
// significant shown digit; ovf flags a negative result with no room for it.
//
// Optional feature: define CALC_DISPLAY_BLINK_EN to enable display flashing
// driven by the blink input (otherwise blink is ignored).
//
// Ports:
//   clk    in   1             system clock, rising edge
//   rst    in   1             synchronous active-high reset
//   value  in   4*NUM_DIGITS  BCD result, nibble 0 = units
//   neg    in   1             result is negative
//   load   in   1             one-cycle capture strobe for value/neg
//   blink  in   1             flash request
//   seg    out  7             segments {g..a}, active-low
//   an     out  NUM_DIGITS    digit enables, active-low one-hot
//   ovf    out  1             negative result with no free sign position

module calc_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 2**25
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      neg,
   input  logic                      load,
   input  logic                      blink,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      ovf
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);

   localparam logic [6:0] SEG_OFF   = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b011_1111;

   logic [4*NUM_DIGITS-1:0] shadow_value;
   logic                    shadow_neg;
   logic [RW-1:0]           refresh_cnt;
   logic [IW-1:0]           scan_idx;

   logic [IW-1:0]           msd;
   logic [3:0]              cur_nib;
   logic [6:0]              digit_seg;
   logic                    sign_ovf;
   logic                    blank_now;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'd0:    glyph = 7'b100_0000;
         4'd1:    glyph = 7'b111_1001;
         4'd2:    glyph = 7'b010_0100;
         4'd3:    glyph = 7'b011_0000;
         4'd4:    glyph = 7'b001_1001;
         4'd5:    glyph = 7'b001_0010;
         4'd6:    glyph = 7'b000_0010;
         4'd7:    glyph = 7'b111_1000;
         4'd8:    glyph = 7'b000_0000;
         4'd9:    glyph = 7'b001_0000;
         default: glyph = SEG_OFF;
      endcase
   endfunction

   // Most significant digit that is not blanked. Ascending scan so the last
   // non-zero nibble wins; the units digit is the floor when all are zero.
   // Invalid nibbles (10..15) count as non-zero: they are shown, as blanks.
   always_comb begin
      msd = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         if (shadow_value[4*k +: 4] != 4'd0) msd = IW'(k);
      end
   end

   always_comb begin
      cur_nib = shadow_value[4*int'(scan_idx) +: 4];
      if (scan_idx <= msd)
         digit_seg = glyph(cur_nib);
      else if (shadow_neg && (int'(scan_idx) == int'(msd) + 1))
         digit_seg = SEG_MINUS;
      else
         digit_seg = SEG_OFF;
   end

   assign sign_ovf = shadow_neg && (int'(msd) == NUM_DIGITS - 1);

`ifdef CALC_DISPLAY_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV);
   logic [BW-1:0] blink_phase;

   // Phase restarts whenever blink is released so each flash begins lit.
   always_ff @(posedge clk) begin
      if (rst || !blink)
         blink_phase <= '0;
      else if (blink_phase == BW'(BLINK_DIV - 1))
         blink_phase <= '0;
      else
         blink_phase <= blink_phase + 1'b1;
   end

   assign blank_now = blink && (blink_phase >= BW'(BLINK_DIV / 2));
`else
   logic unused_blink;
   assign unused_blink = blink | (BLINK_DIV == 0);
   assign blank_now    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_value <= '0;
         shadow_neg   <= 1'b0;
         refresh_cnt  <= '0;
         scan_idx     <= '0;
         seg          <= SEG_OFF;
         an           <= '1;
         ovf          <= 1'b0;
      end else begin
         if (load) begin
            shadow_value <= value;
            shadow_neg   <= neg;
         end

         if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end

         // Outputs reflect the current scan index and shadow contents,
         // so they trail both by one cycle.
         seg <= blank_now ? SEG_OFF : digit_seg;
         an  <= ~(NUM_DIGITS'(1) << scan_idx);
         ovf <= sign_ovf;
      end
   end

endmodule

// File: tb/tb_calc_display_mux.sv
// tb/tb_calc_display_mux.sv - self-checking bench for calc_display_mux

module tb_calc_display_mux;

   localparam int N = 4;
   localparam int R = 4;
   localparam int B = 16;

`ifdef CALC_DISPLAY_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [15:0]   value;
   logic          neg;
   logic          load;
   logic          blink;
   logic [6:0]    seg;
   logic [3:0]    an;
   logic          ovf;

   calc_display_mux #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R),
      .BLINK_DIV   (B)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .neg   (neg),
      .load  (load),
      .blink (blink),
      .seg   (seg),
      .an    (an),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0] glyph_tbl [10] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                                  7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                                  7'b000_0000, 7'b001_0000};

   // Number of displayed digit positions (at least one: the units digit).
   function automatic int shown_width(input logic [15:0] v);
      int w;
      w = 1;
      for (int i = 3; i >= 1; i--) begin
         if (w == 1 && v[4*i +: 4] != 4'd0) w = i + 1;
      end
      return w;
   endfunction

   function automatic logic [6:0] model_seg(input logic [15:0] v, input bit n, input int k);
      int w;
      int d;
      w = shown_width(v);
      d = int'(v[4*k +: 4]);
      if (k < w) return (d <= 9) ? glyph_tbl[d] : 7'h7F;
      if (n && k == w) return 7'b011_1111;
      return 7'h7F;
   endfunction

   logic [15:0] m_value;
   bit          m_neg;
   int          m_n;
   int          m_phase;
   int          m_slot;
   logic [6:0]  exp_seg;
   logic [3:0]  exp_an;
   logic        exp_ovf;
   bit          started = 1'b0;

   always @(posedge clk) begin
      started <= 1'b1;
      if (rst) begin
         exp_seg <= 7'h7F;
         exp_an  <= 4'hF;
         exp_ovf <= 1'b0;
         m_value <= '0;
         m_neg   <= 1'b0;
         m_n     <= 0;
         m_phase <= 0;
      end else begin
         m_slot  = (m_n / R) % N;
         exp_an  <= ~(4'b0001 << m_slot);
         exp_seg <= (BLINK_ON && blink && m_phase >= B / 2) ? 7'h7F
                                                            : model_seg(m_value, m_neg, m_slot);
         exp_ovf <= m_neg && (shown_width(m_value) == N);
         if (load) begin
            m_value <= value;
            m_neg   <= neg;
         end
         m_n     <= m_n + 1;
         m_phase <= blink ? (m_phase + 1) % B : 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_seg", 32'(seg), 32'(exp_seg));
         chk("cyc_an",  32'(an),  32'(exp_an));
         chk("cyc_ovf", 32'(ovf), 32'(exp_ovf));
      end
   end

   // ---------------- directed stimulus ----------------
   logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_seq [4] = '{7'b001_1001, 7'b011_0000, 7'b010_0100, 7'b111_1001};
   logic [6:0] cap [4];

   task automatic do_load(input logic [15:0] v, input logic n);
      value = v;
      neg   = n;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Skip the cycle still showing old data, then record one full scan.
   task automatic capture();
      for (int j = 0; j < 4; j++) cap[j] = 7'bx;
      @(negedge clk);
      for (int c = 0; c < N * R; c++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) if (an[j] == 1'b0) cap[j] = seg;
      end
   endtask

   bit          found;
   logic [3:0]  prev_an;
   logic [31:0] forced;

   initial begin
      rst = 1'b1; value = '0; neg = 1'b0; load = 1'b0; blink = 1'b0;

      // T1 reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t1_rst_seg", 32'(seg), 32'h7F);
      chk("t1_rst_an",  32'(an),  32'hF);
      rst = 1'b0;
      @(negedge clk);
      chk("t1_rel_seg", 32'(seg), 32'b100_0000);
      chk("t1_rel_an",  32'(an),  32'b1110);

      // T2 scan order
      do_load(16'h1234, 1'b0);
      found   = 1'b0;
      prev_an = an;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
         prev_an = an;
      end
      chk("t2_align", 32'(found), 32'd1);
      for (int s = 0; s < 8; s++) begin
         chk("t2_an",  32'(an),  32'(an_seq[s % 4]));
         chk("t2_seg", 32'(seg), 32'(seg_seq[s % 4]));
         repeat (R) @(negedge clk);
      end

      // T3 blanking and sign
      do_load(16'h0042, 1'b1);
      capture();
      chk("t3_d3", 32'(cap[3]), 32'h7F);
      chk("t3_d2", 32'(cap[2]), 32'b011_1111);
      chk("t3_d1", 32'(cap[1]), 32'b001_1001);
      chk("t3_d0", 32'(cap[0]), 32'b010_0100);
      chk("t3_ovf", 32'(ovf), 32'd0);

      // T4 overflow and invalid digit
      do_load(16'h9876, 1'b1);
      capture();
      chk("t4_ovf", 32'(ovf), 32'd1);
      chk("t4_d3", 32'(cap[3]), 32'b001_0000);
      chk("t4_d2", 32'(cap[2]), 32'b000_0000);
      chk("t4_d1", 32'(cap[1]), 32'b111_1000);
      chk("t4_d0", 32'(cap[0]), 32'b000_0010);
      do_load(16'h00A5, 1'b0);
      capture();
      chk("t4b_d2", 32'(cap[2]), 32'h7F);
      chk("t4b_d1", 32'(cap[1]), 32'h7F);
      chk("t4b_d0", 32'(cap[0]), 32'b001_0010);

      // T5 reset mid-scan, with ovf set beforehand
      do_load(16'h9876, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (an == 4'b1011) found = 1'b1;
      end
      chk("t5_find", 32'(found), 32'd1);
      chk("t5_pre_ovf", 32'(ovf), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_an",  32'(an),  32'hF);
      chk("t5_rst_ovf", 32'(ovf), 32'd0);
      chk("t5_rst_seg", 32'(seg), 32'h7F);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rel_an",  32'(an),  32'b1110);
      chk("t5_rel_seg", 32'(seg), 32'b100_0000);
      capture();
      chk("t5_d1", 32'(cap[1]), 32'h7F);

      // T6 blink
      do_load(16'h8888, 1'b0);
      @(negedge clk);
      blink  = 1'b1;
      forced = '0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         forced[k] = (seg == 7'h7F);
      end
      blink = 1'b0;
      chk("t6_pattern", forced, BLINK_ON ? 32'hFF00_FF00 : 32'h0);
      repeat (8) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
